trax_move_decoder: RTL and testbench

Byte-stream parser between the UART receive path of the transceiver and the game controller. Consumes ASCII Trax notation lines (colour announcement or one move per line), converts each move into the 22-bit packed move word `{type[1:0], col[9:0], row[9:0]}`, and flags completion with a single-cycle pulse. The pulse is edge-detected by the game controller. Malformed lines are discarded whole and never reach the controller.

---
 rtl/trax_pkg.sv | 38 +++
 rtl/trax_ascii_class.sv | 36 +++
 rtl/trax_move_decoder.sv | 145 ++++++++++++++
 tb/tb_trax_move_decoder.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/trax_pkg.sv
// Shared constants for the Trax move decoder: tile codes, move-word layout, ASCII codes, FSM states.
package trax_pkg;
  localparam int MOVE_W         = 22;
  localparam int FIELD_W        = 10;
  localparam int TYPE_LSB       = 20;
  localparam int COL_LSB        = 10;
  localparam int ROW_LSB        = 0;
  localparam int MAX_ROW_DEF    = 20;
  localparam int MAX_COL_DEF    = 20;
  localparam int MAX_DIGITS_DEF = 3;

  localparam logic [1:0] TILE_PLUS   = 2'b01;
  localparam logic [1:0] TILE_SLASH  = 2'b10;
  localparam logic [1:0] TILE_BSLASH = 2'b11;

  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_AT       = 8'h40;
  localparam logic [7:0] CH_COL_LAST = 8'h5A;
  localparam logic [7:0] CH_DASH     = 8'h2D;
  localparam logic [7:0] CH_W        = 8'h57;
  localparam logic [7:0] CH_B        = 8'h42;
  localparam logic [7:0] CH_PLUS     = 8'h2B;
  localparam logic [7:0] CH_SLASH    = 8'h2F;
  localparam logic [7:0] CH_BSLASH   = 8'h5C;
  localparam logic [7:0] CH_ZERO     = 8'h30;
  localparam logic [7:0] CH_NINE     = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE, ST_COLOR, ST_COLOR_EOL, ST_ROW_FIRST, ST_ROW, ST_EOL, ST_SKIP
  } state_t;

  function automatic logic [MOVE_W-1:0] pack_move(input logic [1:0] tile,
                                                  input logic [FIELD_W-1:0] col,
                                                  input logic [FIELD_W-1:0] row);
    return {tile, col, row};
  endfunction
endpackage

// File: rtl/trax_ascii_class.sv
// Combinational byte classifier: digits, column letters ('@'..'Z'), tile glyphs, LF and CR.
module trax_ascii_class
  import trax_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_col,
  output logic [9:0] col,
  output logic       is_tile,
  output logic [1:0] tile,
  output logic       is_lf,
  output logic       is_cr
);
  logic [7:0] col_off;

  always_comb begin
    is_digit = (ch >= CH_ZERO) && (ch <= CH_NINE);
    digit    = ch[3:0];
    is_col   = (ch >= CH_AT) && (ch <= CH_COL_LAST);
    col_off  = ch - CH_AT;
    col      = {2'b00, col_off};
    is_lf    = (ch == CH_LF);
    is_cr    = (ch == CH_CR);
    is_tile  = 1'b1;
    case (ch)
      CH_PLUS:   tile = TILE_PLUS;
      CH_SLASH:  tile = TILE_SLASH;
      CH_BSLASH: tile = TILE_BSLASH;
      default: begin
        tile    = 2'b00;
        is_tile = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/trax_move_decoder.sv
// Trax notation line parser: colour lines and moves into a 22-bit move word.
// Optional TRAX_DEC_ERR_CNT_EN adds a saturating err_count of discarded lines.
module trax_move_decoder
  import trax_pkg::*;
#(
  parameter int MAX_ROW    = MAX_ROW_DEF,
  parameter int MAX_COL    = MAX_COL_DEF,
  parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [21:0] move_out,
  output logic        end_receive,
  output logic        color,
  output logic        color_valid,
  output logic        err_pulse
`ifdef TRAX_DEC_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [9:0] ROW_LIM = 10'(MAX_ROW);
  localparam logic [9:0] COL_LIM = 10'(MAX_COL);
  localparam logic [CNT_W-1:0] DIG_MAX = CNT_W'(MAX_DIGITS);

  state_t state, state_nxt;
  logic [9:0]       row_acc, col_acc;
  logic [1:0]       tile_acc;
  logic [CNT_W-1:0] dig_cnt;
  logic             pend_color;

  logic       is_digit, is_col, is_tile, is_lf, is_cr;
  logic [3:0] digit;
  logic [9:0] col;
  logic [1:0] tile;

  trax_ascii_class u_cls (
    .ch(rx_data), .is_digit(is_digit), .digit(digit), .is_col(is_col), .col(col),
    .is_tile(is_tile), .tile(tile), .is_lf(is_lf), .is_cr(is_cr)
  );

  logic        active, lf_now, in_range, dig_full, is_wb;
  logic [13:0] row_mac;
  logic [9:0]  row_sat;
  logic        do_move, do_err, do_color;

  always_comb begin
    active   = rx_valid && !is_cr;
    lf_now   = active && is_lf;
    is_wb    = (rx_data == CH_W) || (rx_data == CH_B);
    dig_full = (dig_cnt == DIG_MAX);
    in_range = (row_acc < ROW_LIM) && (col_acc < COL_LIM);
    row_mac  = {4'b0, row_acc} * 14'd10 + {10'b0, digit};
    // saturating at 1023 keeps an overflowed row out of range forever
    row_sat  = (row_mac > 14'd1023) ? 10'h3FF : row_mac[9:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // an LF mid-line ends it as a discard rather than swallowing the next line
  always_comb begin
    state_nxt = state;
    if (active) begin
      case (state)
        ST_IDLE:
          if (rx_data == CH_DASH) state_nxt = ST_COLOR;
          else if (is_col)        state_nxt = ST_ROW_FIRST;
          else if (!is_lf)        state_nxt = ST_SKIP;
        ST_COLOR:     state_nxt = is_wb ? ST_COLOR_EOL : (is_lf ? ST_IDLE : ST_SKIP);
        ST_COLOR_EOL: state_nxt = is_lf ? ST_IDLE : ST_SKIP;
        ST_ROW_FIRST: state_nxt = is_digit ? ST_ROW : (is_lf ? ST_IDLE : ST_SKIP);
        ST_ROW:
          if (is_digit && !dig_full) state_nxt = ST_ROW;
          else if (is_tile)          state_nxt = ST_EOL;
          else if (is_lf)            state_nxt = ST_IDLE;
          else                       state_nxt = ST_SKIP;
        ST_EOL:       state_nxt = is_lf ? ST_IDLE : ST_SKIP;
        ST_SKIP:      if (is_lf) state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    do_color = lf_now && (state == ST_COLOR_EOL);
    do_move  = lf_now && (state == ST_EOL) && in_range;
    do_err   = lf_now && ((state == ST_COLOR) || (state == ST_ROW_FIRST) ||
                          (state == ST_ROW)   || (state == ST_SKIP) ||
                          ((state == ST_EOL) && !in_range));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      move_out    <= '0;
      end_receive <= 1'b0;
      err_pulse   <= 1'b0;
      color       <= 1'b0;
      color_valid <= 1'b0;
      row_acc     <= '0;
      col_acc     <= '0;
      tile_acc    <= '0;
      dig_cnt     <= '0;
      pend_color  <= 1'b0;
    end else begin
      end_receive <= do_move;
      err_pulse   <= do_err;
      if (do_move) move_out <= pack_move(tile_acc, col_acc, row_acc);
      if (do_color) begin
        color       <= pend_color;
        color_valid <= 1'b1;
      end
      if (active) begin
        case (state)
          ST_IDLE:      if (is_col) col_acc <= col;
          ST_COLOR:     if (is_wb) pend_color <= (rx_data == CH_B);
          ST_ROW_FIRST: if (is_digit) begin
            row_acc <= {6'b0, digit};
            dig_cnt <= CNT_W'(1);
          end
          ST_ROW:
            if (is_digit && !dig_full) begin
              row_acc <= row_sat;
              dig_cnt <= dig_cnt + 1'b1;
            end else if (is_tile) begin
              tile_acc <= tile;
            end
          default: ;
        endcase
      end
    end
  end

`ifdef TRAX_DEC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                          err_count <= '0;
    else if (do_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_trax_move_decoder.sv
// Scoreboard bench for trax_move_decoder: stimulus pushes expected pulses, a negedge monitor pops them.
module tb_trax_move_decoder;
  import trax_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [21:0] move_out;
  logic        end_receive, color, color_valid, err_pulse;
`ifdef TRAX_DEC_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  trax_move_decoder dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .move_out(move_out), .end_receive(end_receive), .color(color),
    .color_valid(color_valid), .err_pulse(err_pulse)
`ifdef TRAX_DEC_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [21:0] mv;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic line(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic exp_move(input logic [21:0] mv);
    exp_t e;
    e.is_err = 1'b0; e.mv = mv; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic exp_err(input logic [21:0] mv);
    exp_t e;
    e.is_err = 1'b1; e.mv = mv; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic chk_reset_vals();
    chk("rst_move_out", 32'(move_out), 32'h0);
    chk("rst_end_receive", 32'(end_receive), 32'h0);
    chk("rst_err_pulse", 32'(err_pulse), 32'h0);
    chk("rst_color", 32'(color), 32'h0);
    chk("rst_color_valid", 32'(color_valid), 32'h0);
`ifdef TRAX_DEC_ERR_CNT_EN
    chk("rst_err_count", 32'(err_count), 32'h0);
`endif
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (end_receive || err_pulse) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: end_receive=%0b err_pulse=%0b want none",
                 end_receive, err_pulse);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", {30'b0, end_receive, err_pulse}, e.is_err ? 32'h1 : 32'h2);
        chk("move_out", 32'(move_out), 32'(e.mv));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  localparam logic [21:0] MV_S19 = {TILE_SLASH, 10'd19, 10'd19};

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_vals();

    line("-B\n");
    @(negedge clk);
    chk("color_black", 32'(color), 32'h1);
    chk("color_valid", 32'(color_valid), 32'h1);
    line("-W\r\n");
    @(negedge clk);
    chk("color_white", 32'(color), 32'h0);
    chk("color_valid_held", 32'(color_valid), 32'h1);

    line("\n");
    line("@0+\n");  exp_move({TILE_PLUS, 10'd0, 10'd0});
    line("C12\\\n"); exp_move({TILE_BSLASH, 10'd3, 10'd12});
    line("A3/\n");  exp_move({TILE_SLASH, 10'd1, 10'd3});
    line("A25+\n"); exp_err({TILE_SLASH, 10'd1, 10'd3});
    line("A1234/\n"); exp_err({TILE_SLASH, 10'd1, 10'd3});
`ifdef TRAX_DEC_ERR_CNT_EN
    @(negedge clk);
    chk("err_count_2", 32'(err_count), 32'd2);
`endif
    line("S19/\n"); exp_move(MV_S19);
    line("U1+\n");  exp_err(MV_S19);
    line("A20+\n"); exp_err(MV_S19);
    line("Bx\n");   exp_err(MV_S19);
    line("B2+\n");  exp_move({TILE_PLUS, 10'd2, 10'd2});
`ifdef TRAX_DEC_ERR_CNT_EN
    @(negedge clk);
    chk("err_count_5", 32'(err_count), 32'd5);
`endif

    line("D1");
    reset = 1'b1;
    send(CH_LF);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    line("B1+\n");  exp_move({TILE_PLUS, 10'd2, 10'd1});

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
